// File: rtl/fport_pkg.sv
`default_nettype none
// =====================================================================
// fport_pkg - F.Port protocol constants, FSM state types, CRC helper
// Rev 1.0 - initial release
// =====================================================================
package fport_pkg;

  localparam logic [7:0] FLAG_BYTE    = 8'h7E;
  localparam logic [7:0] ESC_BYTE     = 8'h7D;
  localparam logic [7:0] ESC_XOR      = 8'h20;
  localparam logic [7:0] LEN_CONTROL  = 8'h19;
  localparam logic [7:0] TYPE_CONTROL = 8'h00;
  localparam logic [7:0] CRC_GOOD     = 8'hFF;

  localparam int NUM_DATA_BYTES = 22;
  localparam int NUM_CHANNELS   = 16;
  localparam int CHANNEL_BITS   = 11;
  localparam int PAYLOAD_BITS   = NUM_DATA_BYTES * 8;
  // Body byte index of rssi: channel bytes, then flags, then rssi
  localparam int LAST_BODY_BYTE = NUM_DATA_BYTES + 1;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    ST_HUNT, ST_LEN, ST_TYPE, ST_DATA, ST_CRC, ST_END, ST_EMIT
  } frame_state_t;

  function automatic logic [7:0] crc_add(input logic [7:0] acc, input logic [7:0] data);
    logic [8:0] sum;
    sum = {1'b0, acc} + {1'b0, data};
    return sum[7:0] + {7'd0, sum[8]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fport_uart_rx.sv
`default_nettype none
// =====================================================================
// fport_uart_rx - 8N1 LSB-first byte receiver, samples at mid-bit
// Rev 1.0 - initial release
// =====================================================================
module fport_uart_rx
  import fport_pkg::*;
#(
  parameter int clocks_per_bit = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_error
);

  localparam int CNT_W = $clog2(clocks_per_bit);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(clocks_per_bit - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(clocks_per_bit / 2 - 1);

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shifter, shifter_n, data_n;
  logic             valid_n, stop_err_n;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shifter    <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      stop_error <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bit_idx    <= bit_idx_n;
      shifter    <= shifter_n;
      byte_valid <= valid_n;
      byte_data  <= data_n;
      stop_error <= stop_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_idx_n  = bit_idx;
    shifter_n  = shifter;
    data_n     = byte_data;
    valid_n    = 1'b0;
    stop_err_n = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx) begin
          state_n = RX_START;
          cnt_n   = '0;
        end
      end
      RX_START: begin
        // A start bit that has gone high again by mid-bit was a glitch
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          shifter_n = {rx, shifter[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          state_n    = RX_IDLE;
          valid_n    = rx;
          stop_err_n = !rx;
          if (rx) data_n = shifter;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fport_frame_decoder.sv
`default_nettype none
// =====================================================================
// fport_frame_decoder - F.Port control-frame decoder with change reporting
// Rev 1.0 - initial release
// =====================================================================
module fport_frame_decoder
  import fport_pkg::*;
#(
  parameter int clocks_per_bit = 434,
  parameter int inverted       = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fport_rx,
  output logic        channel_changed,
  output logic [3:0]  channel_index,
  output logic [10:0] channel_value,
  output logic        failsafe,
  output logic [7:0]  rssi,
  output logic        frame_ok,
  output logic        frame_error
);

  localparam logic LINE_INV  = (inverted != 0);
  localparam logic LINE_IDLE = ~LINE_INV;

  logic [1:0] rx_sync;
  logic       rx_line, byte_valid, stop_error;
  logic [7:0] byte_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rx_sync <= {2{LINE_IDLE}};
    else          rx_sync <= {rx_sync[0], fport_rx};
  end
  assign rx_line = rx_sync[1] ^ LINE_INV;

  fport_uart_rx #(.clocks_per_bit(clocks_per_bit)) u_uart_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx_line),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_error (stop_error)
  );

  frame_state_t            state, state_n;
  logic [7:0]              crc, crc_n, dec_byte, crc_next;
  logic [4:0]              body_cnt, body_cnt_n;
  logic                    esc, esc_n;
  logic                    body_we, commit, ok_n, err_n;
  logic [PAYLOAD_BITS-1:0] shadow, committed;
  logic [7:0]              flags_sh, rssi_sh, emit_base;
  logic [3:0]              emit_idx;
  logic [NUM_CHANNELS-1:0] seen;
  logic [CHANNEL_BITS-1:0] last_val [NUM_CHANNELS];
  logic [CHANNEL_BITS-1:0] emit_val;

  assign dec_byte  = esc ? (byte_data ^ ESC_XOR) : byte_data;
  assign crc_next  = crc_add(crc, dec_byte);
  assign emit_base = 8'(emit_idx) * 8'(CHANNEL_BITS);
  assign emit_val  = committed[emit_base +: CHANNEL_BITS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_HUNT;
      crc      <= '0;
      body_cnt <= '0;
      esc      <= 1'b0;
    end else begin
      state    <= state_n;
      crc      <= crc_n;
      body_cnt <= body_cnt_n;
      esc      <= esc_n;
    end
  end

  // A byte needs >= 40 clocks, so none can complete inside the 16-cycle EMIT window
  always_comb begin
    state_n    = state;
    crc_n      = crc;
    body_cnt_n = body_cnt;
    esc_n      = esc;
    body_we    = 1'b0;
    commit     = 1'b0;
    ok_n       = 1'b0;
    err_n      = 1'b0;
    if (state == ST_EMIT) begin
      if (emit_idx == 4'(NUM_CHANNELS - 1)) state_n = ST_LEN;
    end else if (stop_error) begin
      state_n = ST_HUNT;
      esc_n   = 1'b0;
    end else if (byte_valid) begin
      if (byte_data == FLAG_BYTE) begin
        state_n = ST_LEN;
        esc_n   = 1'b0;
        if (state == ST_END && !esc) begin
          if (crc == CRC_GOOD) begin
            commit  = 1'b1;
            ok_n    = 1'b1;
            state_n = ST_EMIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end else if (byte_data == ESC_BYTE) begin
        esc_n = 1'b1;
      end else begin
        esc_n = 1'b0;
        case (state)
          ST_LEN: begin
            if (dec_byte == LEN_CONTROL) begin
              state_n = ST_TYPE;
              crc_n   = dec_byte;
            end else begin
              state_n = ST_HUNT;
              err_n   = 1'b1;
            end
          end
          ST_TYPE: begin
            state_n    = (dec_byte == TYPE_CONTROL) ? ST_DATA : ST_HUNT;
            crc_n      = crc_next;
            body_cnt_n = '0;
          end
          ST_DATA: begin
            body_we    = 1'b1;
            crc_n      = crc_next;
            body_cnt_n = body_cnt + 1'b1;
            if (body_cnt == 5'(LAST_BODY_BYTE)) state_n = ST_CRC;
          end
          ST_CRC: begin
            crc_n   = crc_next;
            state_n = ST_END;
          end
          default: state_n = ST_HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow          <= '0;
      committed       <= '0;
      flags_sh        <= '0;
      rssi_sh         <= '0;
      emit_idx        <= '0;
      seen            <= '0;
      for (int n = 0; n < NUM_CHANNELS; n++) last_val[n] <= '0;
      channel_changed <= 1'b0;
      channel_index   <= '0;
      channel_value   <= '0;
      failsafe        <= 1'b0;
      rssi            <= '0;
      frame_ok        <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      frame_ok        <= ok_n;
      frame_error     <= err_n;
      channel_changed <= 1'b0;
      if (body_we) begin
        if (body_cnt < 5'(NUM_DATA_BYTES))       shadow[{body_cnt, 3'b000} +: 8] <= dec_byte;
        else if (body_cnt == 5'(NUM_DATA_BYTES)) flags_sh <= dec_byte;
        else                                     rssi_sh  <= dec_byte;
      end
      if (commit) begin
        committed <= shadow;
        failsafe  <= flags_sh[3];
        rssi      <= rssi_sh;
        emit_idx  <= '0;
      end
      if (state == ST_EMIT) begin
        emit_idx <= emit_idx + 1'b1;
        if (!seen[emit_idx] || last_val[emit_idx] != emit_val) begin
          channel_changed    <= 1'b1;
          channel_index      <= emit_idx;
          channel_value      <= emit_val;
          last_val[emit_idx] <= emit_val;
          seen[emit_idx]     <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fport_frame_decoder.sv
`default_nettype none
// tb_fport_frame_decoder - scoreboard bench: expected channel updates queued as frames are sent
module tb_fport_frame_decoder;

  localparam int CPB    = 8;
  localparam int SETTLE = 40;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  logic        fport_rx = 1'b0;
  logic        channel_changed, failsafe, frame_ok, frame_error;
  logic [3:0]  channel_index;
  logic [10:0] channel_value;
  logic [7:0]  rssi;

  fport_frame_decoder #(.clocks_per_bit(CPB), .inverted(1)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .fport_rx        (fport_rx),
    .channel_changed (channel_changed),
    .channel_index   (channel_index),
    .channel_value   (channel_value),
    .failsafe        (failsafe),
    .rssi            (rssi),
    .frame_ok        (frame_ok),
    .frame_error     (frame_error)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [3:0] idx; logic [10:0] val; } chg_t;
  chg_t        exp_q[$];
  chg_t        exp_item;
  int          checks = 0, errors = 0;
  int          n_chg = 0, n_ok = 0, n_err = 0;
  int          cyc = 0, first_cyc = 0, last_cyc = 0;
  logic [10:0] chans  [16];
  logic [10:0] m_last [16];
  logic [15:0] m_seen = '0;
  logic [7:0]  fb     [27];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Output monitor: every channel_changed pulse is popped against the scoreboard
  initial forever begin
    @(negedge clock);
    if (frame_ok) n_ok++;
    if (frame_error) n_err++;
    if (channel_changed) begin
      if (n_chg == 0) first_cyc = cyc;
      last_cyc = cyc;
      n_chg++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL chg_unexpected: got idx=%0d val=%0d, required no pulse", channel_index, channel_value);
      end else begin
        exp_item = exp_q.pop_front();
        if ({channel_index, channel_value} !== exp_item) begin
          errors++;
          $display("FAIL chg_value: got idx=%0d val=%0d, required idx=%0d val=%0d",
                   channel_index, channel_value, exp_item.idx, exp_item.val);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic line_bit(input logic b);
    fport_rx = ~b;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_raw(input logic [7:0] b);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(1'b1);
  endtask

  task automatic send_stuffed(input logic [7:0] b);
    if (b == 8'h7E || b == 8'h7D) begin
      send_raw(8'h7D);
      send_raw(b ^ 8'h20);
    end else begin
      send_raw(b);
    end
  endtask

  task automatic build_frame(input logic [7:0] flags, input logic [7:0] rs, input logic [7:0] crc_delta);
    logic [175:0] pl;
    int           sum;
    for (int n = 0; n < 16; n++) pl[11*n +: 11] = chans[n];
    fb[0] = 8'h19;
    fb[1] = 8'h00;
    for (int i = 0; i < 22; i++) fb[2+i] = pl[8*i +: 8];
    fb[24] = flags;
    fb[25] = rs;
    sum = 0;
    for (int i = 0; i < 26; i++) sum += fb[i];
    while (sum > 255) sum = (sum & 255) + (sum >> 8);
    fb[26] = 8'hFF - 8'(sum) + crc_delta;
  endtask

  task automatic send_frame();
    send_raw(8'h7E);
    for (int i = 0; i < 27; i++) send_stuffed(fb[i]);
    send_raw(8'h7E);
    repeat (SETTLE) @(negedge clock);
  endtask

  task automatic expect_changes();
    for (int n = 0; n < 16; n++) begin
      if (!m_seen[n] || m_last[n] != chans[n]) exp_q.push_back(chg_t'({4'(n), chans[n]}));
      m_last[n] = chans[n];
      m_seen[n] = 1'b1;
    end
  endtask

  task automatic clear_counts();
    n_chg = 0;
    n_ok  = 0;
    n_err = 0;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    fport_rx = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if ({channel_changed, frame_ok, frame_error, failsafe} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000", {channel_changed, frame_ok, frame_error, failsafe});
    end
    checks++;
    if (channel_index !== 4'd0 || channel_value !== 11'd0) begin
      errors++;
      $display("FAIL reset_channel: got idx=%0d val=%0d, required 0/0", channel_index, channel_value);
    end
    checks++;
    if (rssi !== 8'd0) begin
      errors++;
      $display("FAIL reset_rssi: got %h, required 00", rssi);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_first_frame();
    for (int n = 0; n < 16; n++) chans[n] = 11'd992;
    build_frame(8'h00, 8'h50, 8'h00);
    clear_counts();
    expect_changes();
    send_frame();
    checks++;
    if (n_ok != 1 || n_err != 0) begin
      errors++;
      $display("FAIL first_status: got ok=%0d err=%0d, required ok=1 err=0", n_ok, n_err);
    end
    checks++;
    if (n_chg != 16 || last_cyc - first_cyc != 15) begin
      errors++;
      $display("FAIL first_burst: got %0d pulses over %0d cycles, required 16 over 15", n_chg, last_cyc - first_cyc);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL first_missing: got %0d pending, required 0", exp_q.size());
    end
    checks++;
    if (rssi !== 8'h50 || failsafe !== 1'b0) begin
      errors++;
      $display("FAIL first_telemetry: got rssi=%h fs=%b, required rssi=50 fs=0", rssi, failsafe);
    end
  endtask

  task automatic test_single_change();
    chans[5] = 11'd1811;
    build_frame(8'h00, 8'h50, 8'h00);
    clear_counts();
    expect_changes();
    send_frame();
    checks++;
    if (n_ok != 1 || n_chg != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_change: got ok=%0d pulses=%0d pending=%0d, required 1/1/0", n_ok, n_chg, exp_q.size());
    end
  endtask

  task automatic test_bad_crc();
    chans[0] = 11'd100;
    build_frame(8'h00, 8'h33, 8'h01);
    clear_counts();
    send_frame();
    chans[0] = 11'd992;
    checks++;
    if (n_err != 1 || n_ok != 0 || n_chg != 0) begin
      errors++;
      $display("FAIL bad_crc: got err=%0d ok=%0d pulses=%0d, required 1/0/0", n_err, n_ok, n_chg);
    end
    checks++;
    if (rssi !== 8'h50) begin
      errors++;
      $display("FAIL bad_crc_rssi: got %h, required 50", rssi);
    end
  endtask

  task automatic test_stuffing();
    chans[0] = 11'h57E;
    chans[1] = 11'h20F;
    build_frame(8'h00, 8'h7D, 8'h00);
    clear_counts();
    expect_changes();
    send_frame();
    checks++;
    if (n_ok != 1 || n_err != 0 || n_chg != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stuffing: got ok=%0d err=%0d pulses=%0d pending=%0d, required 1/0/2/0",
               n_ok, n_err, n_chg, exp_q.size());
    end
    checks++;
    if (rssi !== 8'h7D) begin
      errors++;
      $display("FAIL stuffing_rssi: got %h, required 7d", rssi);
    end
  endtask

  task automatic test_failsafe_restart();
    chans[2] = 11'd200;
    build_frame(8'h08, 8'h50, 8'h00);
    clear_counts();
    expect_changes();
    send_raw(8'h7E);
    for (int i = 0; i < 13; i++) send_stuffed(fb[i]);
    send_frame();
    checks++;
    if (n_ok != 1 || n_err != 0 || n_chg != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart: got ok=%0d err=%0d pulses=%0d pending=%0d, required 1/0/1/0",
               n_ok, n_err, n_chg, exp_q.size());
    end
    checks++;
    if (failsafe !== 1'b1) begin
      errors++;
      $display("FAIL failsafe: got %b, required 1", failsafe);
    end
  endtask

  task automatic test_reset_mid_emit();
    bit found;
    for (int n = 0; n < 16; n++) chans[n] = 11'd500;
    build_frame(8'h00, 8'h50, 8'h00);
    clear_counts();
    expect_changes();
    send_raw(8'h7E);
    for (int i = 0; i < 27; i++) send_stuffed(fb[i]);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(1'b0 ^ (i >= 1 && i <= 6));
    fport_rx = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clock);
      if (channel_changed && channel_index == 4'd7) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL emit_timeout: channel 7 pulse not seen, required within 200 cycles");
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({channel_changed, frame_ok, frame_error, failsafe, channel_index, channel_value, rssi} !== 27'd0) begin
      errors++;
      $display("FAIL mid_emit_reset: got chg=%b idx=%0d val=%0d rssi=%h fs=%b, required all 0",
               channel_changed, channel_index, channel_value, rssi, failsafe);
    end
    checks++;
    if (n_chg != 8) begin
      errors++;
      $display("FAIL mid_emit_count: got %0d pulses before reset, required 8", n_chg);
    end
    exp_q.delete();
    m_seen = '0;
    repeat (4) @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    clear_counts();
    expect_changes();
    send_frame();
    checks++;
    if (n_ok != 1 || n_chg != 16 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL after_reset: got ok=%0d pulses=%0d pending=%0d, required 1/16/0", n_ok, n_chg, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_single_change();
    test_bad_crc();
    test_stuffing();
    test_failsafe_restart();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
